vga_sync_param_module: RTL

VGA_SYNC_PARAM_MODULE -- requirements
Module: vga_sync_param_module

---
 rtl/vga_timing_pkg.sv | 20 ++
 rtl/vga_delay_line.sv | 27 ++
 rtl/vga_sync_param_module.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared widths and standard VGA timing sets
package vga_timing_pkg;
  localparam int ADDR_W = 11;
  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } vga_axis_t;
  localparam vga_axis_t H_640_25 = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam vga_axis_t V_640_25 = '{active: 480, fp: 10, sync: 2, bp: 33};
  localparam vga_axis_t H_800_40 = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam vga_axis_t V_800_40 = '{active: 600, fp: 1, sync: 4, bp: 23};
  function automatic int axis_total(vga_axis_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register with async clear, wire when DEPTH=0
module vga_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] CLR = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  if (DEPTH == 0) begin : g_pass
    assign o_q = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_pipe [DEPTH];
    // shift one stage per clock, clear every stage to CLR on reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < DEPTH; i++) r_pipe[i] <= CLR;
      end else begin
        r_pipe[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
    assign o_q = r_pipe[DEPTH-1];
  end
endmodule

// File: rtl/vga_sync_param_module.sv
// vga_sync_param_module: parameterised VGA timing generator with latency-matched sync and blanking
module vga_sync_param_module
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_800_40.active,
  parameter int   H_FP     = H_800_40.fp,
  parameter int   H_SYNC   = H_800_40.sync,
  parameter int   H_BP     = H_800_40.bp,
  parameter int   V_ACTIVE = V_800_40.active,
  parameter int   V_FP     = V_800_40.fp,
  parameter int   V_SYNC   = V_800_40.sync,
  parameter int   V_BP     = V_800_40.bp,
  parameter logic H_POL    = 1'b1,
  parameter logic V_POL    = 1'b1,
  parameter int   PIX_LAT  = 1
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              En,
  input  logic [R_W-1:0]    Red_In,
  input  logic [G_W-1:0]    Green_In,
  input  logic [B_W-1:0]    Blue_In,
  output logic              Ready_Sig,
  output logic [ADDR_W-1:0] Column_Addr_Sig,
  output logic [ADDR_W-1:0] Row_Addr_Sig,
  output logic              Frame_Start_Sig,
  output logic [15:0]       Frame_Cnt,
  output logic              HSYNC_Sig,
  output logic              VSYNC_Sig,
  output logic [R_W-1:0]    Red_Sig,
  output logic [G_W-1:0]    Green_Sig,
  output logic [B_W-1:0]    Blue_Sig
);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [ADDR_W-1:0] r_h, r_v;
  logic [15:0]       r_frame_cnt;
  logic              r_hsync, r_vsync;
  logic [R_W-1:0]    r_red;
  logic [G_W-1:0]    r_green;
  logic [B_W-1:0]    r_blue;
  logic [11:0]       w_h, w_v;
  logic              w_live, w_h_last, w_v_last;
  logic [2:0]        w_pipe_in, w_pipe_out;

  // RST_n in the live term keeps the combinational outputs quiet during reset
  assign w_live   = RST_n & En;
  assign w_h      = {1'b0, r_h};
  assign w_v      = {1'b0, r_v};
  assign w_h_last = w_h == H_LAST;
  assign w_v_last = w_v == V_LAST;

  // h/v raster counters and completed-frame count; En low parks the raster at the origin
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_h         <= '0;
      r_v         <= '0;
      r_frame_cnt <= '0;
    end else if (!En) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h_last ? '0 : r_h + 11'd1;
      if (w_h_last) r_v <= w_v_last ? '0 : r_v + 11'd1;
      if (w_h_last && w_v_last) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign Column_Addr_Sig = r_h;
  assign Row_Addr_Sig    = r_v;
  assign Frame_Cnt       = r_frame_cnt;
  assign Ready_Sig       = w_live && w_h < H_ACT && w_v < V_ACT;
  assign Frame_Start_Sig = w_live && r_h == '0 && r_v == '0;
  assign w_pipe_in = {w_live && w_h >= H_SS && w_h < H_SE,
                      w_live && w_v >= V_SS && w_v < V_SE,
                      Ready_Sig};

  // the pixel source answers PIX_LAT cycles later; the output stage below adds the last cycle
  vga_delay_line #(.DEPTH(PIX_LAT), .WIDTH(3), .CLR(3'b000)) u_dl (
    .i_clk  (CLK),
    .i_rst_n(RST_n),
    .i_d    (w_pipe_in),
    .o_q    (w_pipe_out)
  );

  // panel-side register stage: apply sync polarity and blank RGB with the matched data-enable
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_hsync <= ~H_POL;
      r_vsync <= ~V_POL;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_hsync <= w_pipe_out[2] ? H_POL : ~H_POL;
      r_vsync <= w_pipe_out[1] ? V_POL : ~V_POL;
      r_red   <= w_pipe_out[0] ? Red_In : '0;
      r_green <= w_pipe_out[0] ? Green_In : '0;
      r_blue  <= w_pipe_out[0] ? Blue_In : '0;
    end
  end

  assign HSYNC_Sig = r_hsync;
  assign VSYNC_Sig = r_vsync;
  assign Red_Sig   = r_red;
  assign Green_Sig = r_green;
  assign Blue_Sig  = r_blue;
endmodule
